dp_mem_responder: RTL and testbench
===================================

Name: dp_mem_responder

Overview:
- Memory-side responder for the pipelined datapath's instruction and data request ports.
- The datapath holds imemREN/dmemREN/dmemWEN high until it sees the matching ihit/dhit.
- This block arbitrates those requests onto the single-port RAM, tracks RAM latency through ramstate, and returns ihit/dhit plus load data.
- Sits between the datapath (EX/MEM and fetch requesters) and the RAM model.

Parameters:
- TIMEOUT_CYC, 64, cycles without ramstate==ACCESS before an access is aborted.
- STARVE_LIM, 4, consecutive data grants allowed while an instruction request waits before the instruction port is forced a grant.

Ports:
- CLK  input  1  clock
- nRST  input  1  reset, asynchronous, active-low
- imemREN  input  1  instruction read request (level, held until ihit)
- imemaddr  input  32  instruction word address
- dmemREN  input  1  data read request (level, held until dhit)
- dmemWEN  input  1  data write request (level, held until dhit)
- dmemaddr  input  32  data address
- dmemstore  input  32  data write value
- ihit  output  1  instruction access complete, one-cycle pulse
- dhit  output  1  data access complete, one-cycle pulse
- imemload  output  32  instruction read data
- dmemload  output  32  data read data
- ramREN  output  1  RAM read enable
- ramWEN  output  1  RAM write enable
- ramaddr  output  32  RAM address
- ramstore  output  32  RAM write data
- ramload  input  32  RAM read data
- ramstate  input  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- timeout_flag  output  1  sticky, set on any access abort
- err_count  output  8  saturating count of ERROR responses

Behaviour:
- Reset values (nRST low, asynchronous):
  - state=IDLE; all enables, ihit, dhit, timeout_flag = 0.
  - imemload, dmemload, ramaddr, ramstore, err_count, wait counter, starve counter = 0.
- FSM states: IDLE, DACC, IACC.
- IDLE arbitration, evaluated each cycle:
  - If starve counter == STARVE_LIM and imemREN, go to IACC.
  - Else if dmemREN|dmemWEN, go to DACC.
  - Else if imemREN, go to IACC.
  - On entry, latch addr and store data plus op (read/write). Zero-cycle grant: no hit in IDLE.
- dmemREN and dmemWEN both high: treated as a write.
- DACC/IACC: drive ramREN or ramWEN and ramaddr/ramstore from the latched values only. Datapath changes mid-access are ignored.
- Completion: when ramstate==ACCESS, assert the matching hit combinationally in that cycle.
  - Reads: dmemload/imemload = ramload combinationally in the hit cycle, then held by a capture register until the next hit on that port.
  - Next state = IDLE, so minimum latency = 2 cycles from request to hit.
- ramstate==ERROR:
  - No hit; err_count +1 (saturating at 255); return to IDLE.
  - A still-asserted request is re-arbitrated, which is an implicit retry.
- ramstate FREE/BUSY: stay in state; wait counter +1.
- Timeout: wait counter reaching TIMEOUT_CYC-1 without ACCESS sets timeout_flag (sticky until reset), aborts to IDLE, no hit. The wait counter clears on every state entry.
- Starve counter:
  - +1 (saturating) on each DACC grant made while imemREN is high.
  - Cleared on each IACC grant, and whenever imemREN is low in IDLE.
- RAM enables are low in IDLE, so there is never a back-to-back RAM command without one IDLE cycle.
- Reset mid-access: abort immediately, no hit, RAM enables drop asynchronously.

Decomposition:
- ramstate_t is in cpu_types_pkg. Add memctl_state_t {IDLE, DACC, IACC} to cpu_types_pkg.
- Optional sub-module mem_wait_timer (loadable counter with terminal flag) for the TIMEOUT_CYC watchdog. Everything else stays in one module.

Test Plan:
- dmemREN=1, dmemaddr=0x100, RAM gives ACCESS after 3 BUSY cycles with ramload=0xDEADBEEF -> dhit pulses exactly once on cycle 5; dmemload=0xDEADBEEF; ihit stays 0.
- imemREN and dmemWEN both high at once, dmemstore=0x12345678 -> ramWEN first with ramaddr=dmemaddr; dhit; then IACC; ihit follows ≥2 cycles later.
- dmemREN held continuously, imemREN high, STARVE_LIM=4 -> 4 data grants then 1 instruction grant; counter resets.
- ramstate=ERROR on first DACC cycle, request held -> err_count=1, no dhit, retry succeeds with a dhit on the next ACCESS.
- ramstate stuck BUSY for 64 cycles -> timeout_flag=1 at cycle 64, FSM back to IDLE, no hit.
- nRST asserted while in DACC -> ramREN/ramWEN=0 immediately; after release, state=IDLE and err_count=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types used by the datapath memory responder.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE,
        DACC,
        IACC
    } memctl_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] store;
        logic        wr;
    } memreq_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dp_mem_responder_if.sv
// Datapath request/response and RAM command bundle.
interface dp_mem_responder_if;
    import cpu_types_pkg::*;

    logic        imemREN;
    logic [31:0] imemaddr;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        ihit;
    logic        dhit;
    logic [31:0] imemload;
    logic [31:0] dmemload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    ramstate_t   ramstate;

    modport master (
        output imemREN, imemaddr,
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        output ramload, ramstate,
        input  ihit, dhit, imemload, dmemload,
        input  ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        input  imemREN, imemaddr,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  ramload, ramstate,
        output ihit, dhit, imemload, dmemload,
        output ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/dp_mem_responder_timer.sv
// Wait watchdog: counts stalled RAM cycles, flags when TERM is reached.
module mem_wait_timer #(
    parameter int TERM = 63
) (
    input  logic CLK,
    input  logic nRST,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam int W = $clog2(TERM + 1) + 1;

    logic [W-1:0] cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !term) begin
            cnt <= cnt + W'(1);
        end
    end

    assign term = (cnt == W'(TERM));

endmodule

// File: rtl/dp_mem_responder.sv
// Arbitrates datapath I/D requests onto the single-port RAM and returns hits.
module dp_mem_responder
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int STARVE_LIM  = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    dp_mem_responder_if.slave bus,
    output logic              timeout_flag,
    output logic [7:0]        err_count
);

    memctl_state_t state;
    memctl_state_t nxt;
    memreq_t       req_q;
    logic [7:0]    starve;
    logic [31:0]   iload_q;
    logic [31:0]   dload_q;
    logic          grant_d;
    logic          grant_i;
    logic          dreq;
    logic          starve_hit;
    logic          in_acc;
    logic          ram_wait;
    logic          ram_done;
    logic          wt_term;
    logic          tmo;

    assign dreq       = bus.dmemREN | bus.dmemWEN;
    assign starve_hit = (starve == 8'(STARVE_LIM)) & bus.imemREN;
    assign in_acc     = (state == DACC) | (state == IACC);
    assign ram_wait   = (bus.ramstate == FREE) | (bus.ramstate == BUSY);
    assign ram_done   = (bus.ramstate == ACCESS) | (bus.ramstate == ERROR);
    assign tmo        = in_acc & ram_wait & wt_term;

    // Idle cycles hold the watchdog at zero, so every access starts fresh
    mem_wait_timer #(
        .TERM(TIMEOUT_CYC - 1)
    ) u_wait (
        .CLK (CLK),
        .nRST(nRST),
        .clr (!in_acc),
        .en  (in_acc & ram_wait),
        .term(wt_term)
    );

    always_comb begin
        nxt     = state;
        grant_d = 1'b0;
        grant_i = 1'b0;
        unique case (state)
            IDLE: begin
                if (starve_hit) begin
                    grant_i = 1'b1;
                end else if (dreq) begin
                    grant_d = 1'b1;
                end else if (bus.imemREN) begin
                    grant_i = 1'b1;
                end
                if (grant_d) begin
                    nxt = DACC;
                end else if (grant_i) begin
                    nxt = IACC;
                end
            end
            DACC, IACC: begin
                if (ram_done || tmo) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // Enables decode from state alone so an async reset drops them at once
    assign bus.ramREN   = (state == IACC) | ((state == DACC) & !req_q.wr);
    assign bus.ramWEN   = (state == DACC) & req_q.wr;
    assign bus.ramaddr  = req_q.addr;
    assign bus.ramstore = req_q.store;

    assign bus.ihit = (state == IACC) & (bus.ramstate == ACCESS);
    assign bus.dhit = (state == DACC) & (bus.ramstate == ACCESS);

    assign bus.imemload = bus.ihit ? bus.ramload : iload_q;
    assign bus.dmemload = (bus.dhit & !req_q.wr) ? bus.ramload : dload_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= IDLE;
            req_q        <= '0;
            starve       <= '0;
            iload_q      <= '0;
            dload_q      <= '0;
            timeout_flag <= 1'b0;
            err_count    <= '0;
        end else begin
            state <= nxt;

            if (grant_d) begin
                req_q <= '{addr:  bus.dmemaddr,
                           store: bus.dmemstore,
                           wr:    bus.dmemWEN};
            end else if (grant_i) begin
                req_q <= '{addr:  bus.imemaddr,
                           store: req_q.store,
                           wr:    1'b0};
            end

            if (grant_i) begin
                starve <= '0;
            end else if (grant_d && bus.imemREN) begin
                if (starve != 8'(STARVE_LIM)) begin
                    starve <= starve + 8'd1;
                end
            end else if ((state == IDLE) && !bus.imemREN) begin
                starve <= '0;
            end

            if (bus.ihit) begin
                iload_q <= bus.ramload;
            end
            if (bus.dhit && !req_q.wr) begin
                dload_q <= bus.ramload;
            end

            if (tmo) begin
                timeout_flag <= 1'b1;
            end
            if (in_acc && (bus.ramstate == ERROR)) begin
                err_count <= sat_inc8(err_count);
            end
        end
    end

endmodule

// File: tb/tb_dp_mem_responder.sv
// Scoreboard bench for dp_mem_responder with a latency-randomised RAM model.
module tb_dp_mem_responder;
    import cpu_types_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        bit          wr;
    } exp_t;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       timeout_flag;
    logic [7:0] err_count;

    dp_mem_responder_if bus();

    dp_mem_responder #(
        .TIMEOUT_CYC(64),
        .STARVE_LIM (4)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .bus         (bus),
        .timeout_flag(timeout_flag),
        .err_count   (err_count)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int dhit_n = 0;
    int ihit_n = 0;
    int dhit_cyc = 0;
    int ihit_cyc = 0;
    exp_t dq[$];
    exp_t iq[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] ram_mem [logic [31:0]];

    int ram_lat_fix = 1;
    bit ram_stuck = 1'b0;
    bit ram_err_once = 1'b0;
    int ram_err_pct = 0;
    int err_issued = 0;

    function automatic logic [31:0] seed_val(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : seed_val(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    always @(posedge CLK) cyc++;

    // RAM model: each new command waits some BUSY cycles then answers
    initial begin : ram_model
        int left;
        bit err;
        bit active;
        left = 0;
        err = 1'b0;
        active = 1'b0;
        bus.ramstate = FREE;
        bus.ramload = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (!(bus.ramREN || bus.ramWEN)) begin
                active = 1'b0;
                bus.ramstate = FREE;
            end else begin
                if (!active) begin
                    active = 1'b1;
                    left = (ram_lat_fix >= 0) ? ram_lat_fix
                                              : int'($urandom_range(0, 4));
                    err = ram_err_once ||
                          (int'($urandom_range(0, 99)) < ram_err_pct);
                    if (ram_err_once) left = 0;
                    ram_err_once = 1'b0;
                end
                if (ram_stuck || left > 0) begin
                    bus.ramstate = BUSY;
                    if (left > 0) left--;
                end else if (err) begin
                    bus.ramstate = ERROR;
                    err_issued++;
                end else begin
                    bus.ramstate = ACCESS;
                    if (bus.ramWEN) begin
                        ram_mem[bus.ramaddr] = bus.ramstore;
                    end else begin
                        bus.ramload = ram_mem.exists(bus.ramaddr) ?
                                      ram_mem[bus.ramaddr] :
                                      seed_val(bus.ramaddr);
                    end
                end
            end
        end
    end

    // op: 0 read, 1 write, 2 both enables (behaves as write)
    task automatic dreq(input logic [31:0] a, input logic [31:0] d,
                        input int op, output int lat);
        exp_t e;
        e.a = a;
        e.wr = (op != 0);
        if (e.wr) begin
            e.d = d;
            ref_mem[a] = d;
        end else begin
            e.d = ref_rd(a);
        end
        dq.push_back(e);
        bus.dmemaddr = a;
        bus.dmemstore = d;
        bus.dmemREN = (op != 1);
        bus.dmemWEN = (op != 0);
        lat = 0;
        for (int n = 1; n <= 500; n++) begin
            @(negedge CLK);
            if (bus.dhit) begin
                lat = n;
                break;
            end
        end
        chk("dhit_wait", 32'(lat != 0), 1);
        @(posedge CLK);
        #1;
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
    endtask

    task automatic ireq(input logic [31:0] a, output int lat);
        exp_t e;
        e.a = a;
        e.wr = 1'b0;
        e.d = ref_rd(a);
        iq.push_back(e);
        bus.imemaddr = a;
        bus.imemREN = 1'b1;
        lat = 0;
        for (int n = 1; n <= 500; n++) begin
            @(negedge CLK);
            if (bus.ihit) begin
                lat = n;
                break;
            end
        end
        chk("ihit_wait", 32'(lat != 0), 1);
        @(posedge CLK);
        #1;
        bus.imemREN = 1'b0;
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (bus.dhit) begin
            dhit_n++;
            dhit_cyc = cyc;
            if (dq.size() == 0) begin
                chk("dhit_spurious", bus.dhit, 0);
            end else begin
                e = dq.pop_front();
                chk("d_addr", bus.ramaddr, e.a);
                if (e.wr) begin
                    chk("d_wen", bus.ramWEN, 1);
                    chk("d_store", bus.ramstore, e.d);
                end else begin
                    chk("d_load", bus.dmemload, e.d);
                end
            end
        end
        if (bus.ihit) begin
            ihit_n++;
            ihit_cyc = cyc;
            if (iq.size() == 0) begin
                chk("ihit_spurious", bus.ihit, 0);
            end else begin
                e = iq.pop_front();
                chk("i_addr", bus.ramaddr, e.a);
                chk("i_load", bus.imemload, e.d);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat;
        int lat2;
        int t;
        int d0;
        int d1;
        nRST = 1'b0;
        bus.imemREN = 1'b0;
        bus.imemaddr = '0;
        bus.dmemREN = 1'b0;
        bus.dmemWEN = 1'b0;
        bus.dmemaddr = '0;
        bus.dmemstore = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ihit", bus.ihit, 0);
        chk("rst_dhit", bus.dhit, 0);
        chk("rst_ramREN", bus.ramREN, 0);
        chk("rst_ramWEN", bus.ramWEN, 0);
        chk("rst_timeout", timeout_flag, 0);
        chk("rst_errcnt", err_count, 0);
        chk("rst_imemload", bus.imemload, 0);
        chk("rst_dmemload", bus.dmemload, 0);
        chk("rst_ramaddr", bus.ramaddr, 0);
        chk("rst_ramstore", bus.ramstore, 0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // read with three BUSY cycles: hit on the fifth cycle
        ram_mem[32'h100] = 32'hDEADBEEF;
        ref_mem[32'h100] = 32'hDEADBEEF;
        ram_lat_fix = 3;
        t = ihit_n;
        dreq(32'h100, 32'h0, 0, lat);
        chk("t1_lat", lat, 5);
        chk("t1_no_ihit", ihit_n, t);
        chk("t1_dload_hold", bus.dmemload, 32'hDEADBEEF);

        // simultaneous write (both enables) and fetch: data first
        ram_lat_fix = 0;
        fork
            dreq(32'h140, 32'h12345678, 2, lat);
            ireq(32'h8000, lat2);
        join
        chk("t3_d_first", 32'(dhit_cyc < ihit_cyc), 1);
        chk("t3_i_gap", 32'((ihit_cyc - dhit_cyc) >= 2), 1);
        chk("t3_ram_written", ram_mem[32'h140], 32'h12345678);

        // continuous data stream with a waiting fetch
        ram_lat_fix = 1;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    dreq(32'h100 + 32'(4 * k), 32'h0, 0, lat);
                end
            end
            begin
                d0 = dhit_n;
                ireq(32'h8010, lat2);
                d1 = dhit_n;
                chk("starve_first", d1 - d0, 4);
                ireq(32'h8014, lat2);
                chk("starve_again", dhit_n - d1, 4);
            end
        join

        // ERROR on first access cycle, request held, implicit retry
        ram_lat_fix = 0;
        ram_err_once = 1'b1;
        t = dhit_n;
        dreq(32'h180, 32'h0, 0, lat);
        chk("err_lat", lat, 4);
        chk("err_count", err_count, 1);
        chk("err_one_dhit", dhit_n - t, 1);

        // RAM stuck BUSY: abort after 64 access cycles
        ram_stuck = 1'b1;
        t = dhit_n;
        bus.dmemaddr = 32'h1C0;
        bus.dmemREN = 1'b1;
        @(posedge CLK);
        #1;
        bus.dmemREN = 1'b0;
        repeat (64) @(negedge CLK);
        chk("to_flag_pre", timeout_flag, 0);
        chk("to_still_acc", bus.ramREN, 1);
        @(negedge CLK);
        chk("to_flag", timeout_flag, 1);
        chk("to_idle", bus.ramREN, 0);
        chk("to_no_hit", dhit_n, t);
        @(posedge CLK);
        #1;

        // reset while in DACC
        bus.dmemaddr = 32'h1C4;
        bus.dmemREN = 1'b1;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #3;
        chk("rst_pre_ren", bus.ramREN, 1);
        nRST = 1'b0;
        #1;
        chk("rst_ren_drop", bus.ramREN, 0);
        chk("rst_flag_clr", timeout_flag, 0);
        chk("rst_err_clr", err_count, 0);
        chk("rst_dload_clr", bus.dmemload, 0);
        bus.dmemREN = 1'b0;
        ram_stuck = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        err_issued = 0;
        @(negedge CLK);
        chk("rst_idle", 32'(bus.ramREN | bus.ramWEN), 0);
        @(posedge CLK);
        #1;

        // random traffic on both ports with random latency and errors
        ram_lat_fix = -1;
        ram_err_pct = 10;
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    dreq(32'h100 + 32'(4 * $urandom_range(0, 31)),
                         $urandom, int'($urandom_range(0, 2)), lat);
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge CLK);
                        #1;
                    end
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    ireq(32'h8000 + 32'(4 * $urandom_range(0, 63)), lat2);
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge CLK);
                        #1;
                    end
                end
            end
        join
        ram_err_pct = 0;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        chk("dq_empty", dq.size(), 0);
        chk("iq_empty", iq.size(), 0);
        chk("err_final", err_count, (err_issued > 255) ? 255 : err_issued);
        chk("to_flag_after_rst", timeout_flag, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
